// File: rtl/text_blitter.sv
// Renders a COLS x ROWS character buffer into a pixel framebuffer through an 8x8 font ROM.
// One pixel per accepted framebuffer beat; outputs hold while fb_ready is low.
module text_blitter #(
  parameter int COLS = 40,
  parameter int ROWS = 25
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] fg,
  input  logic [23:0] bg,
  output logic        busy,
  output logic        done,
  output logic [9:0]  txt_adr,
  input  logic [7:0]  txt_d,
  output logic [10:0] font_adr,
  input  logic [7:0]  font_d,
  output logic [15:0] fb_wadr,
  output logic [23:0] fb_d,
  output logic        fb_we,
  input  logic        fb_ready
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_CHAR,
    WAIT_CHAR,
    FETCH_GLYPH,
    WAIT_GLYPH,
    WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    grow_q, grow_d;
  logic [2:0]    px_q, px_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    bits_q, bits_d;
  logic [23:0]   fg_q, fg_d;
  logic [23:0]   bg_q, bg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [9:0]    txt_adr_q;
  logic [10:0]   font_adr_q;
  logic          last_col, last_row;

  assign last_col = (int'(col_q) == COLS - 1);
  assign last_row = (int'(row_q) == ROWS - 1);

  // Pixel address is a pure function of the position counters, so it stays put during stalls.
  assign fb_wadr = 16'((int'(row_q) * 8 + int'(grow_q)) * (COLS * 8) + int'(col_q) * 8 + int'(px_q));
  assign fb_d    = bits_q[7] ? fg_q : bg_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    grow_d   = grow_q;
    px_d     = px_q;
    char_d   = char_q;
    bits_d   = bits_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    txt_adr  = txt_adr_q;
    font_adr = font_adr_q;
    fb_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          fg_d    = fg;
          bg_d    = bg;
          col_d   = '0;
          row_d   = '0;
          grow_d  = 3'd0;
          px_d    = 3'd0;
          busy_d  = 1'b1;
          state_d = FETCH_CHAR;
        end
      end
      FETCH_CHAR: begin
        txt_adr = 10'(int'(row_q) * COLS + int'(col_q));
        state_d = WAIT_CHAR;
      end
      WAIT_CHAR: begin
        char_d  = txt_d;
        state_d = FETCH_GLYPH;
      end
      FETCH_GLYPH: begin
        font_adr = {char_q, grow_q};
        state_d  = WAIT_GLYPH;
      end
      WAIT_GLYPH: begin
        bits_d  = font_d;
        px_d    = 3'd0;
        state_d = WRITE;
      end
      WRITE: begin
        fb_we = 1'b1;
        if (fb_ready) begin
          px_d   = px_q + 3'd1;
          bits_d = {bits_q[6:0], 1'b0};
          if (px_q == 3'd7) begin
            if (grow_q != 3'd7) begin
              grow_d  = grow_q + 3'd1;
              state_d = FETCH_GLYPH;
            end else begin
              grow_d = 3'd0;
              if (!last_col) begin
                col_d   = col_q + 1'b1;
                state_d = FETCH_CHAR;
              end else if (!last_row) begin
                col_d   = '0;
                row_d   = row_q + 1'b1;
                state_d = FETCH_CHAR;
              end else begin
                col_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      grow_q     <= 3'd0;
      px_q       <= 3'd0;
      char_q     <= 8'd0;
      bits_q     <= 8'd0;
      fg_q       <= 24'd0;
      bg_q       <= 24'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      txt_adr_q  <= 10'd0;
      font_adr_q <= 11'd0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      grow_q     <= grow_d;
      px_q       <= px_d;
      char_q     <= char_d;
      bits_q     <= bits_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      txt_adr_q  <= txt_adr;
      font_adr_q <= font_adr;
    end
  end

endmodule

// File: tb/tb_text_blitter.sv
// Randomized frames on a small text grid, checked pixel by pixel against a nested-loop model.
module tb_text_blitter;

  localparam int COLS = 5;
  localparam int ROWS = 3;
  localparam int NCH  = COLS * ROWS;
  localparam int NPIX = NCH * 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] fg = 24'd0, bg = 24'd0;
  logic        busy, done, fb_we;
  logic [9:0]  txt_adr;
  logic [10:0] font_adr;
  logic [7:0]  txt_d = 8'd0, font_d = 8'd0;
  logic [15:0] fb_wadr;
  logic [23:0] fb_d;
  logic        fb_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  txt_mem  [0:1023];
  logic [7:0]  font_mem [0:2047];
  logic [23:0] fb_mem   [0:NPIX-1];
  logic [39:0] exp_q[$];
  int          writes, done_cnt, first_we_cyc, done_cyc;
  logic [15:0] last_addr, ninth_addr;
  logic [23:0] last_data;

  text_blitter #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLOCK_50(clk), .reset(rst_n), .start(start), .fg(fg), .bg(bg),
    .busy(busy), .done(done), .txt_adr(txt_adr), .txt_d(txt_d),
    .font_adr(font_adr), .font_d(font_d), .fb_wadr(fb_wadr), .fb_d(fb_d),
    .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data appears one cycle after the address.
  always @(posedge clk) begin
    txt_d  <= txt_mem[txt_adr];
    font_d <= font_mem[font_adr];
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build_model(input logic [23:0] fgv, input logic [23:0] bgv);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int gr = 0; gr < 8; gr++)
        for (int c = 0; c < COLS; c++) begin end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int gr = 0; gr < 8; gr++)
          for (int p = 0; p < 8; p++) begin
            logic [7:0] g;
            int a;
            g = font_mem[int'(txt_mem[r * COLS + c]) * 8 + gr];
            a = (r * 8 + gr) * (COLS * 8) + c * 8 + p;
            exp_q.push_back({16'(a), g[7 - p] ? fgv : bgv});
          end
  endfunction

  task automatic randomize_content();
    for (int i = 0; i < 1024; i++) txt_mem[i] = (i < NCH) ? 8'($urandom) : 8'd0;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
  endtask

  // Entered at a negedge; leaves at a negedge.
  task automatic run_frame(input int ready_pct, input logic [23:0] fgv, input logic [23:0] bgv,
                           input int extra_start_cyc, input int reset_write, input bit b2b);
    int cyc, budget;
    bit finished, stalled, aborted;
    logic [15:0] s_addr;
    logic [23:0] s_data;
    logic [39:0] e;
    build_model(fgv, bgv);
    for (int i = 0; i < NPIX; i++) fb_mem[i] = 'x;
    writes = 0; done_cnt = 0; first_we_cyc = 0; done_cyc = 0;
    cyc = 0; finished = 0; stalled = 0; aborted = 0;
    s_addr = '0; s_data = '0;
    budget = 82 * NCH * 6 + 200;
    fg = fgv; bg = bgv; start = 1'b1;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_start_cyc);
      if (stalled) begin
        chk("stall we", 40'(fb_we), 40'd1);
        chk("stall addr", 40'(fb_wadr), 40'(s_addr));
        chk("stall data", 40'(fb_d), 40'(s_data));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
        chk("model drained", 40'(exp_q.size()), 40'd0);
        chk("busy at done", 40'(busy), 40'd0);
      end else begin
        chk("busy in frame", 40'(busy), 40'd1);
      end
      fb_ready = ($urandom_range(99) < ready_pct);
      if (fb_we && first_we_cyc == 0) first_we_cyc = cyc;
      if (fb_we && reset_write > 0 && writes == reset_write - 1) begin
        rst_n = 1'b0;
        #1;
        chk("rst we", 40'(fb_we), 40'd0);
        chk("rst busy", 40'(busy), 40'd0);
        chk("rst done", 40'(done), 40'd0);
        chk("rst wadr", 40'(fb_wadr), 40'd0);
        chk("rst fbd", 40'(fb_d), 40'd0);
        chk("rst txtadr", 40'(txt_adr), 40'd0);
        chk("rst fontadr", 40'(font_adr), 40'd0);
        aborted = 1;
        finished = 1;
      end else if (fb_we && fb_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra write", 40'(writes), 40'(NPIX));
        end else begin
          e = exp_q.pop_front();
          chk("wr addr", 40'(fb_wadr), 40'(e[39:24]));
          chk("wr data", 40'(fb_d), 40'(e[23:0]));
        end
        if (int'(fb_wadr) < NPIX) fb_mem[fb_wadr] = fb_d;
        if (writes == 8) ninth_addr = fb_wadr;
        last_addr = fb_wadr;
        last_data = fb_d;
        writes++;
        stalled = 0;
      end else if (fb_we) begin
        stalled = 1;
        s_addr = fb_wadr;
        s_data = fb_d;
      end else begin
        stalled = 0;
      end
    end
    chk("frame finished", 40'(finished), 40'd1);
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("no done after reset", 40'(done), 40'd0);
        chk("idle after reset", 40'(busy), 40'd0);
      end
    end else begin
      chk("write count", 40'(writes), 40'(NPIX));
      chk("done count", 40'(done_cnt), 40'd1);
      if (ready_pct == 100) begin
        chk("first we cycle", 40'(first_we_cyc), 40'd5);
        chk("done cycle", 40'(done_cyc), 40'(82 * NCH + 1));
      end
      if (!b2b) begin
        @(negedge clk);
        chk("done pulse width", 40'(done), 40'd0);
        chk("busy after done", 40'(busy), 40'd0);
        chk("we idle", 40'(fb_we), 40'd0);
      end
    end
  endtask

  initial begin
    int nbg;
    logic [23:0] f, b;
    for (int i = 0; i < 1024; i++) txt_mem[i] = 8'd0;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'd0;
    #2;
    chk("reset busy", 40'(busy), 40'd0);
    chk("reset done", 40'(done), 40'd0);
    chk("reset we", 40'(fb_we), 40'd0);
    chk("reset wadr", 40'(fb_wadr), 40'd0);
    chk("reset fbd", 40'(fb_d), 40'd0);
    chk("reset txtadr", 40'(txt_adr), 40'd0);
    chk("reset fontadr", 40'(font_adr), 40'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Blank text, blank glyph: every pixel is background.
    f = 24'($urandom);
    run_frame(100, f, 24'h0000FF, 0, 0, 0);
    nbg = 0;
    for (int i = 0; i < NPIX; i++) if (fb_mem[i] === 24'h0000FF) nbg++;
    chk("all bg", 40'(nbg), 40'(NPIX));

    // Directed glyph bits at the first and last characters.
    randomize_content();
    txt_mem[0] = 8'h41;
    font_mem[8'h41 * 8] = 8'h81;
    txt_mem[NCH - 1] = 8'h5A;
    font_mem[8'h5A * 8 + 7] = 8'h01;
    b = 24'($urandom);
    run_frame(100, 24'hFF0000, b, 0, 0, 0);
    chk("px0 fg", 40'(fb_mem[0]), 40'h00FF0000);
    chk("px7 fg", 40'(fb_mem[7]), 40'h00FF0000);
    for (int i = 1; i < 7; i++) chk("px mid bg", 40'(fb_mem[i]), 40'(b));
    chk("row1 start", 40'(ninth_addr), 40'(COLS * 8));
    chk("last addr", 40'(last_addr), 40'(NPIX - 1));
    chk("last data", 40'(last_data), 40'h00FF0000);

    // Random stalls with a stray start pulse mid-frame.
    randomize_content();
    run_frame(50, 24'($urandom), 24'($urandom), 200, 0, 0);

    // Start accepted in the done cycle of the previous frame.
    randomize_content();
    run_frame(70, 24'($urandom), 24'($urandom), 0, 0, 1);
    randomize_content();
    run_frame(100, 24'($urandom), 24'($urandom), 0, 0, 0);

    // Reset during the 100th write, then a clean frame.
    randomize_content();
    run_frame(60, 24'($urandom), 24'($urandom), 0, 100, 0);
    randomize_content();
    run_frame(100, 24'($urandom), 24'($urandom), 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
